out_port_uart_tx: RTL and testbench
===================================

# out_port_uart_tx

Serial transmit stage downstream of the CPU data path's output port. It captures each 32-bit word the data path writes to the output port, at the same clock edge the OutPort register loads it. Captured words are queued in a small FIFO and shifted out on a single 8N1 UART line as four bytes, least-significant byte first. The processor never stalls: writes that arrive while the FIFO is full are dropped and flagged.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range 2..65535.
- `FIFO_DEPTH`, 4: word entries; power of two, ≥ 2.
- `clock` in 1: single system clock; all logic is on the rising edge.
- `Reset` in 1: reset, asynchronous and active-low.
- `OutPortin` in 1: OutPort load enable from the control unit; one word is written per high cycle.
- `BusMuxOut` in 32: bus value, sampled when `OutPortin` is high.
- `tx` out 1: serial line; idles high.
- `busy` out 1: high while a frame is on the line or the FIFO is non-empty.
- `fifo_full` out 1: FIFO holds `FIFO_DEPTH` words.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: number of words queued, excluding the word being shifted.
- `overflow` out 1: one-cycle pulse when a write is dropped.

## Operation
- Reset values: `tx`=1, `busy`=0, `fifo_full`=0, `fifo_count`=0, `overflow`=0. FIFO pointers are 0, the FSM is in IDLE and all counters are 0.
- FIFO write: `OutPortin`=1 and (not full, or a pop in the same cycle) → `BusMuxOut` is stored at the write pointer.
- Dropped write: `OutPortin`=1, FIFO full and no pop in the same cycle → the write is dropped, `overflow`=1 next cycle, FIFO unchanged.
- Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. Full/empty is decided from the count.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into a 32-bit shift word, set byte index to 0, go to START. Otherwise stay.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx` = shift word bit [byte*8 + bit]. Each bit is held `CLKS_PER_BIT` cycles. After bit 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. Then, if byte index < 3, increment it and go to START. If byte index = 3, go to IDLE.
- Bytes of one word are sent back-to-back, with no idle gap beyond the stop bit.
- Consecutive words are separated by exactly one IDLE cycle (`tx`=1).
- The bit-period counter is `$clog2(CLKS_PER_BIT)` bits wide. It counts 0..`CLKS_PER_BIT`−1 and resets on every state or bit change.
- `busy` = (state ≠ IDLE) or (`fifo_count` ≠ 0). It is registered.
- Simultaneous write and pop:
  - Non-full FIFO: count is unchanged.
  - Full FIFO: the write is accepted and no overflow is flagged.
- Reset asserted mid-frame: `tx` goes to 1 immediately (asynchronously). The FIFO contents are discarded. The partial frame is not resumed after release.

## Timing
- `tx` is driven from a flop; there is no combinational path from the inputs.
- Write at edge N, FIFO empty, FSM IDLE:
  - the pop occurs at edge N+1;
  - `tx` falls after edge N+2.
- Word duration: 40×`CLKS_PER_BIT` cycles. Word-to-word period is 40×`CLKS_PER_BIT`+1 cycles.
- `fifo_count` and `fifo_full` update on the edge after the write or pop.
- `overflow` is high for the single cycle after the dropped write.
- Sustained write rate must not exceed one word per 40×`CLKS_PER_BIT`+1 cycles to avoid loss.

## Structure
- Shared package `uart_pkg`:
  - state enum IDLE/START/DATA/STOP (2 bits);
  - `UART_BYTES_PER_WORD`=4;
  - `UART_DATA_BITS`=8.
- One sub-module, `word_fifo`:
  - parameterised by depth and width;
  - synchronous write/read, async active-low reset;
  - exposes `count`, `full` and `empty`.
- The top level holds the FSM, the bit-period counter, the bit and byte indices, and the shift word.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- Reset: hold `Reset`=0 for 3 cycles → `tx`=1, `busy`=0, `fifo_count`=0, `overflow`=0.
- Single word: write 0x44332211 → `tx` falls 2 cycles later. Decoded bytes are 0x11, 0x22, 0x33, 0x44, each framed as start 0 and stop 1, with every bit 4 cycles wide. `busy` drops 1 cycle after the last stop bit.
- Back-to-back: write 0xA5A5A5A5 then 0x0000FFFF on consecutive cycles → 8 bytes in order: A5 A5 A5 A5 FF FF 00 00. There is exactly one idle cycle between words.
- Overflow: while word 0 is shifting, write 5 more words → the first 4 are queued and `fifo_full`=1. The 5th pulses `overflow` once. After draining, exactly 5 words have been transmitted.
- Full plus pop: fill the FIFO, then write on the exact cycle of a pop → no `overflow`, `fifo_count` stays 4.
- Reset mid-frame: assert `Reset` during the DATA bit 3 of byte 1 → `tx`=1 in the same cycle. After release, `tx` stays 1 and `busy`=0. A new write of 0x000000C3 then transmits cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the output-port UART transmitter
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam int UART_BYTES_PER_WORD = 4;
   localparam int UART_DATA_BITS      = 8;

endpackage

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - show-ahead word FIFO with occupancy count
module word_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     wr_en_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     rd_en_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             wr_ok;
   logic             rd_ok;

   assign rd_ok = rd_en_i && !empty_o;
   // A read in the same cycle frees the slot, so a full FIFO can still accept.
   assign wr_ok = wr_en_i && (!full_o || rd_ok);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({wr_ok, rd_ok})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;
   assign full_o    = (count_q == CW'(DEPTH));
   assign empty_o   = (count_q == '0);

endmodule

// File: rtl/out_port_uart_tx.sv
// rtl/out_port_uart_tx.sv - queues OutPort words and shifts them out as 8N1 bytes, LSB byte first
module out_port_uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clock,
   input  logic                          Reset,
   input  logic                          OutPortin,
   input  logic [31:0]                   BusMuxOut,
   output logic                          tx,
   output logic                          busy,
   output logic                          fifo_full,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int CW     = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(UART_DATA_BITS);
   localparam int BYTE_W = $clog2(UART_BYTES_PER_WORD);
   localparam int WORD_W = UART_BYTES_PER_WORD * UART_DATA_BITS;

   uart_state_e         state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [BYTE_W-1:0]   byte_q, byte_d;
   logic [WORD_W-1:0]   shift_q, shift_d;
   logic                tx_q, tx_d;
   logic                busy_q, busy_d;
   logic                overflow_q, overflow_d;

   logic                pop;
   logic                fifo_empty;
   logic [WORD_W-1:0]   fifo_rd_data;
   logic                bit_done;

   word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WORD_W)
   ) u_fifo (
      .clk_i     (clock),
      .rst_ni    (Reset),
      .wr_en_i   (OutPortin),
      .wr_data_i (BusMuxOut),
      .rd_en_i   (pop),
      .rd_data_o (fifo_rd_data),
      .count_o   (fifo_count),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign bit_done = (cnt_q == CW'(CLKS_PER_BIT - 1));

   // tx_d is decoded from the current state, so the line lags the FSM by one cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      bit_d   = bit_q;
      byte_d  = byte_q;
      shift_d = shift_q;
      pop     = 1'b0;
      tx_d    = 1'b1;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_rd_data;
               byte_d  = '0;
               state_d = START;
            end
         end
         START: begin
            tx_d = 1'b0;
            if (bit_done) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            tx_d = shift_q[{byte_q, bit_q}];
            if (bit_done) begin
               cnt_d = '0;
               if (bit_q == BIT_W'(UART_DATA_BITS - 1)) state_d = STOP;
               else                                     bit_d   = bit_q + BIT_W'(1);
            end
         end
         STOP: begin
            tx_d = 1'b1;
            if (bit_done) begin
               cnt_d = '0;
               if (byte_q == BYTE_W'(UART_BYTES_PER_WORD - 1)) begin
                  state_d = IDLE;
               end else begin
                  byte_d  = byte_q + BYTE_W'(1);
                  state_d = START;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_d     = (state_q != IDLE) || (fifo_count != '0);
   assign overflow_d = OutPortin && fifo_full && !pop;

   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         byte_q     <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         byte_q     <= byte_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         overflow_q <= overflow_d;
      end
   end

   assign tx       = tx_q;
   assign busy     = busy_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_out_port_uart_tx.sv
// tb/tb_out_port_uart_tx.sv - randomized and directed bench with a word-level model and line decoder
module tb_out_port_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FCW   = $clog2(DEPTH) + 1;
   localparam int WORD_CYCLES = 40 * CPB;

   logic           clock;
   logic           Reset;
   logic           OutPortin;
   logic [31:0]    BusMuxOut;
   logic           tx;
   logic           busy;
   logic           fifo_full;
   logic [FCW-1:0] fifo_count;
   logic           overflow;

   out_port_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clock      (clock),
      .Reset      (Reset),
      .OutPortin  (OutPortin),
      .BusMuxOut  (BusMuxOut),
      .tx         (tx),
      .busy       (busy),
      .fifo_full  (fifo_full),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Word-level model: a queue of pending words and the cycles left in the word being sent.
   logic [31:0] mq[$];
   logic [7:0]  exp_bytes[$];
   int          m_rem = 0;
   int          m_acc = 0;
   bit          m_ovf = 0;
   bit          m_busy = 0;
   bit          pop_now;
   logic [31:0] m_word;

   always @(posedge clock) begin
      if (!Reset) begin
         mq.delete();
         exp_bytes.delete();
         m_rem  = 0;
         m_ovf  = 0;
         m_busy = 0;
      end else begin
         pop_now = (m_rem == 0) && (mq.size() > 0);
         m_busy  = (m_rem > 0) || (mq.size() > 0);
         m_ovf   = 0;
         if (OutPortin && !(mq.size() < DEPTH || pop_now)) m_ovf = 1;
         if (pop_now) begin
            m_word = mq.pop_front();
            for (int b = 0; b < 4; b++) exp_bytes.push_back(m_word[8*b +: 8]);
            m_rem = WORD_CYCLES;
         end else if (m_rem > 0) begin
            m_rem--;
         end
         if (OutPortin && !m_ovf) begin
            mq.push_back(BusMuxOut);
            m_acc++;
         end
      end
   end

   // Line decoder: samples tx once per cycle and rebuilds 8N1 frames.
   int          cyc = 0;
   int          mon_s = -1;
   int          mon_k;
   logic [9:0]  mon_bits;
   bit          mon_bad;
   int          last_end = -100;
   int          gaps[$];
   logic [7:0]  rx_log[$];
   logic [7:0]  rxb;

   always @(negedge clock) begin
      cyc++;
      if (!Reset) begin
         mon_s = -1;
      end else begin
         if (mon_s < 0 && tx === 1'b0) begin
            gaps.push_back(cyc - last_end - 1);
            mon_s    = 0;
            mon_bad  = 0;
            mon_bits = '0;
         end
         if (mon_s >= 0) begin
            mon_k = mon_s / CPB;
            if (mon_s % CPB == 0) mon_bits[mon_k] = tx;
            else if (tx !== mon_bits[mon_k]) mon_bad = 1;
            if (mon_s == 10*CPB - 1) begin
               check("frame", {29'd0, mon_bad, mon_bits[0], mon_bits[9]}, 32'd1);
               rxb = mon_bits[8:1];
               rx_log.push_back(rxb);
               if (exp_bytes.size() == 0) check("rx_extra", 32'd1, 32'd0);
               else                       check("rx_byte", {24'd0, rxb}, {24'd0, exp_bytes.pop_front()});
               last_end = cyc;
               mon_s    = -1;
            end else begin
               mon_s++;
            end
         end
      end
   end

   // Per-cycle status against the model.
   int ovf_pulses = 0;
   always @(negedge clock) begin
      if (!Reset) begin
         check("rst_tx", {31'd0, tx}, 32'd1);
         check("rst_busy", {31'd0, busy}, 32'd0);
         check("rst_count", {{(32-FCW){1'b0}}, fifo_count}, 32'd0);
         check("rst_ovf", {31'd0, overflow}, 32'd0);
      end else begin
         check("fifo_count", {{(32-FCW){1'b0}}, fifo_count}, mq.size());
         check("fifo_full", {31'd0, fifo_full}, {31'd0, mq.size() == DEPTH});
         check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
         check("busy", {31'd0, busy}, {31'd0, m_busy});
      end
      if (overflow === 1'b1) ovf_pulses++;
   end

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic write_word(input logic [31:0] w);
      OutPortin = 1'b1;
      BusMuxOut = w;
      tick();
      OutPortin = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((busy || mq.size() > 0 || m_rem > 0 || exp_bytes.size() > 0) && n < 5000) begin
         tick();
         n++;
      end
      check(tag, {31'd0, n < 5000}, 32'd1);
      repeat (3) tick();
   endtask

   logic [7:0] b2b_exp [8] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h00};
   logic [7:0] single_exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int n;
      int p0;
      int acc0;
      int zeros;

      Reset     = 1'b0;
      OutPortin = 1'b0;
      BusMuxOut = '0;

      // Reset
      repeat (3) tick();
      check("reset_tx", {31'd0, tx}, 32'd1);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_count", {{(32-FCW){1'b0}}, fifo_count}, 32'd0);
      check("reset_ovf", {31'd0, overflow}, 32'd0);
      Reset = 1'b1;
      repeat (2) tick();
      check("post_reset_tx", {31'd0, tx}, 32'd1);

      // Single word
      rx_log.delete();
      write_word(32'h44332211);
      lat = 1;
      while (tx && lat < 50) begin
         tick();
         lat++;
      end
      check("tx_fall_lat", lat, 32'd3);
      n = 0;
      while (rx_log.size() < 4 && n < 1000) begin
         tick();
         n++;
      end
      check("single_timeout", {31'd0, n < 1000}, 32'd1);
      check("busy_last_stop", {31'd0, busy}, 32'd1);
      tick();
      check("busy_drop", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 4; i++)
         check("single_byte", {24'd0, rx_log[i]}, {24'd0, single_exp[i]});

      // Back-to-back words
      repeat (5) tick();
      rx_log.delete();
      gaps.delete();
      OutPortin = 1'b1;
      BusMuxOut = 32'hA5A5A5A5;
      tick();
      BusMuxOut = 32'h0000FFFF;
      tick();
      OutPortin = 1'b0;
      drain("b2b_drain");
      check("b2b_nbytes", rx_log.size(), 32'd8);
      for (int i = 0; i < 8 && i < rx_log.size(); i++)
         check("b2b_byte", {24'd0, rx_log[i]}, {24'd0, b2b_exp[i]});
      for (int i = 1; i < 8 && i < gaps.size(); i++)
         check("b2b_gap", gaps[i], (i == 4) ? 32'd1 : 32'd0);

      // Overflow while word 0 is shifting
      rx_log.delete();
      p0 = ovf_pulses;
      write_word($urandom);
      tick();
      OutPortin = 1'b1;
      for (int i = 0; i < 5; i++) begin
         BusMuxOut = $urandom;
         tick();
         if (i == 3) check("ovf_full", {31'd0, fifo_full}, 32'd1);
      end
      OutPortin = 1'b0;
      check("ovf_pulse", {31'd0, overflow}, 32'd1);
      tick();
      check("ovf_clear", {31'd0, overflow}, 32'd0);
      drain("ovf_drain");
      check("ovf_pulses", ovf_pulses - p0, 32'd1);
      check("ovf_nbytes", rx_log.size(), 32'd20);

      // Write on the exact cycle of a pop from a full FIFO
      rx_log.delete();
      p0 = ovf_pulses;
      write_word($urandom);
      tick();
      OutPortin = 1'b1;
      for (int i = 0; i < 4; i++) begin
         BusMuxOut = $urandom;
         tick();
      end
      OutPortin = 1'b0;
      n = 0;
      while (!(m_rem == 0 && mq.size() == DEPTH) && n < 1000) begin
         tick();
         n++;
      end
      check("fullpop_timeout", {31'd0, n < 1000}, 32'd1);
      write_word(32'hCAFEF00D);
      check("fullpop_no_ovf", {31'd0, overflow}, 32'd0);
      check("fullpop_count", {{(32-FCW){1'b0}}, fifo_count}, 32'd4);
      check("fullpop_full", {31'd0, fifo_full}, 32'd1);
      drain("fullpop_drain");
      check("fullpop_pulses", ovf_pulses - p0, 32'd0);
      check("fullpop_nbytes", rx_log.size(), 32'd24);

      // Reset during data bit 3 of byte 1
      write_word(32'h12340000);
      lat = 1;
      while (tx && lat < 50) begin
         tick();
         lat++;
      end
      repeat (14*CPB + 1) tick();
      check("pre_rst_tx", {31'd0, tx}, 32'd0);
      #2;
      Reset = 1'b0;
      #1;
      check("rst_async_tx", {31'd0, tx}, 32'd1);
      check("rst_async_busy", {31'd0, busy}, 32'd0);
      repeat (3) tick();
      Reset = 1'b1;
      zeros = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (tx !== 1'b1) zeros++;
      end
      check("post_rst_idle_tx", zeros, 32'd0);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      check("post_rst_count", {{(32-FCW){1'b0}}, fifo_count}, 32'd0);
      rx_log.delete();
      write_word(32'h000000C3);
      drain("rst_c3_drain");
      check("rst_c3_nbytes", rx_log.size(), 32'd4);
      if (rx_log.size() == 4) begin
         check("rst_c3_b0", {24'd0, rx_log[0]}, 32'hC3);
         check("rst_c3_b3", {24'd0, rx_log[3]}, 32'h00);
      end

      // Randomized traffic, including bursts that may overflow
      rx_log.delete();
      acc0 = m_acc;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 3)) tick();
         else                           repeat ($urandom_range(20, 250)) tick();
         write_word($urandom);
      end
      drain("rand_drain");
      check("rand_nbytes", rx_log.size(), 4 * (m_acc - acc0));
      check("rand_leftover", exp_bytes.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
